// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a registered carry, LSB first, WIDTH cycles per add.
// A new request is taken in IDLE or DONE only; start during RUN is dropped, not queued.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             last;
  logic             accept;

  always_comb begin
    s       = sa[0] ^ sb[0] ^ carry;
    c       = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    // New bit enters at the MSB so after WIDTH shifts bit 0 is the first sum bit.
    res_nxt = (res >> 1) | (WIDTH'(s) << (WIDTH - 1));
    last    = (cnt == CW'(WIDTH - 1));
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      cnt   <= '0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_nxt;
          carry <= c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= res_nxt;
            cout  <= c;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1: cycle-count reference model plus directed literal checks.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit armed = 0;

  // Reference: an add is "in flight" for rem cycles; when rem runs out the value a+b+cin appears.
  int          m_rem  [2] = '{0, 0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [32:0] m_val  [2] = '{33'd0, 33'd0};
  logic [32:0] m_pend [2] = '{33'd0, 33'd0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input int i, input int w, input logic s, input logic [32:0] opsum);
    logic acc;
    if (rst) begin
      m_rem[i]  = 0;
      m_done[i] = 1'b0;
      m_val[i]  = '0;
    end else begin
      acc       = (m_rem[i] == 0) && s;
      m_done[i] = 1'b0;
      if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_val[i]  = m_pend[i];
          m_done[i] = 1'b1;
        end
      end
      if (acc) begin
        m_pend[i] = opsum;
        m_rem[i]  = w;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) armed = 1;
    model_step(0, 8, start8, 33'(a8) + 33'(b8) + 33'(cin8));
    model_step(1, 1, start1, 33'(a1) + 33'(b1) + 33'(cin1));
  end

  always @(negedge clk) begin
    if (armed) begin
      chk($sformatf("w8_cyc%0d", cyc), 64'({busy8, done8, cout8, sum8}),
          64'({m_rem[0] > 0, m_done[0], m_val[0][8:0]}));
      chk($sformatf("w1_cyc%0d", cyc), 64'({busy1, done1, cout1, sum1}),
          64'({m_rem[1] > 0, m_done[1], m_val[1][1:0]}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                      input logic [8:0] exp, input string nm);
    int n;
    n = 0;
    a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      tick();
      if (done8) n = k;
    end
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_result"}, 64'({cout8, sum8}), 64'(exp));
  endtask

  int exp1 [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

  initial begin
    int n, nd, d1, d2;
    logic [3:0] v;

    repeat (2) tick();
    rst = 1'b0;
    chk("reset_state", 64'({busy8, done8, cout8, sum8}), 64'd0);
    repeat (10) tick();
    chk("idle_state", 64'({busy8, done8, cout8, sum8}), 64'd0);

    add8(8'd100, 8'd55, 1'b0, 9'h09B, "add_100_55");
    add8(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    add8(8'hA5, 8'h5A, 1'b1, 9'h100, "add_a5_5a_c1");

    // WIDTH=1 against the full-adder truth table
    for (int i = 0; i < 8; i++) begin
      v = 4'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      for (int k = 1; k <= 5 && n == 0; k++) begin
        tick();
        if (done1) n = k;
      end
      chk($sformatf("fa_%0d_latency", i), 64'(n), 64'd1);
      chk($sformatf("fa_%0d_result", i), 64'({cout1, sum1}), 64'(exp1[i]));
    end
    tick();

    // start while busy must be dropped
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done8) begin
        nd++;
        chk("ignore_result", 64'({cout8, sum8}), 64'h046);
      end
    end
    chk("ignore_one_done", 64'(nd), 64'd1);

    // back-to-back with start held high
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1;
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 30 && d2 == 0; k++) begin
      tick();
      if (k == 16) chk("b2b_hold", 64'({cout8, sum8}), 64'h030);
      if (done8) begin
        if (d1 == 0) begin
          d1 = k;
          chk("b2b_first", 64'({cout8, sum8}), 64'h030);
        end else begin
          d2 = k;
          start8 = 1'b0;
          chk("b2b_second", 64'({cout8, sum8}), 64'h078);
        end
      end
    end
    chk("b2b_first_latency", 64'(d1), 64'd8);
    chk("b2b_spacing", 64'(d2 - d1), 64'd9);
    start8 = 1'b0;
    repeat (3) tick();

    // reset aborts an operation in flight
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_state", 64'({busy8, done8, cout8, sum8}), 64'd0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) nd++;
    end
    chk("rst_mid_no_done", 64'(nd), 64'd0);
    add8(8'd1, 8'd1, 1'b0, 9'h002, "add_after_rst");

    // random traffic on both instances, occasional reset
    for (int k = 0; k < 800; k++) begin
      rst    = ($urandom_range(0, 99) < 2);
      start8 = 1'($urandom_range(0, 1));
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      a1     = 1'($urandom_range(0, 1));
      b1     = 1'($urandom_range(0, 1));
      cin1   = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
